// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX line arbiter.
package uart_arb_pkg;

  // Byte that terminates a console line and releases the grant.
  localparam logic [7:0] LF = 8'h0A;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    REL_NONE    = 2'd0,
    REL_LINE    = 2'd1,
    REL_MAXLEN  = 2'd2,
    REL_TIMEOUT = 2'd3
  } rel_cause_e;

  // Line feed and length-limit releases share the line_done pulse.
  function automatic logic is_line_rel(input rel_cause_e cause);
    return (cause == REL_LINE) || (cause == REL_MAXLEN);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or above ptr_i,
// wrapping modulo NUM_REQ. Grant is given both one-hot and as an index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  logic             found_s;
  logic [IDX_W-1:0] cand_s;

  // Scan from the pointer upward with wrap and keep the first hit
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found_s   = 1'b0;
    cand_s    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!found_s && req_i[cand_s]) begin
        found_s           = 1'b1;
        gnt_oh_o[cand_s]  = 1'b1;
        gnt_idx_o         = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/uart_tx_line_arbiter.sv
// Shares one UART TX byte port between NUM_REQ requesters, holding each grant
// for a whole text line so console output never interleaves. A grant ends on
// a line feed, after MAX_LINE bytes, or after IDLE_TIMEOUT owner-idle cycles.
module uart_tx_line_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_LINE     = 255,
  parameter int IDLE_TIMEOUT = 1024,
  parameter int OWNER_W      = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic [OWNER_W-1:0]   owner_o,
  output logic                 owner_valid_o,
  output logic                 line_done_o,
  output logic                 timeout_o
);

  localparam int CW = $clog2(MAX_LINE + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  arb_state_e         state_q, state_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic               owner_valid_q, owner_valid_d;
  logic [CW-1:0]      char_cnt_q, char_cnt_d;
  logic [TW-1:0]      idle_cnt_q, idle_cnt_d;
  logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               line_done_q, line_done_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0][7:0] req_bytes_s;
  logic [NUM_REQ-1:0]      gnt_oh_s;
  logic [OWNER_W-1:0]      gnt_idx_s;
  logic                    gnt_any_s;
  logic                    load_en_s;
  logic                    own_valid_s;
  logic [7:0]              own_data_s;
  logic                    accept_s;
  rel_cause_e              rel_cause_s;
  logic [OWNER_W-1:0]      next_ptr_s;

  assign req_bytes_s = req_data_i;
  assign gnt_any_s   = |gnt_oh_s;
  assign load_en_s   = !tx_valid_q || tx_ready_i;
  assign own_valid_s = req_valid_i[owner_q];
  assign own_data_s  = req_bytes_s[owner_q];
  assign accept_s    = (state_q == ARB_LOCKED) && own_valid_s && load_en_s;
  assign next_ptr_s  = (owner_q == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_q + OWNER_W'(1);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OWNER_W)
  ) u_rr_arbiter (
    .req_i     (req_valid_i),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (gnt_oh_s),
    .gnt_idx_o (gnt_idx_s)
  );

  // Only the current owner sees ready, and only when the output stage can load
  always_comb begin
    req_ready_o = '0;
    if ((state_q == ARB_LOCKED) && load_en_s) begin
      req_ready_o[owner_q] = 1'b1;
    end else begin
      req_ready_o = '0;
    end
  end

  // Grant/release state machine with line length and idle bookkeeping
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    char_cnt_d    = char_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    rr_ptr_d      = rr_ptr_q;
    rel_cause_s   = REL_NONE;
    case (state_q)
      ARB_IDLE: begin
        if (gnt_any_s) begin
          state_d       = ARB_LOCKED;
          owner_d       = gnt_idx_s;
          owner_valid_d = 1'b1;
          char_cnt_d    = '0;
          idle_cnt_d    = '0;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_LOCKED: begin
        if (accept_s) begin
          // An accepted byte always clears idle, so a line feed wins over timeout.
          char_cnt_d = char_cnt_q + CW'(1);
          idle_cnt_d = '0;
          if (own_data_s == LF) begin
            rel_cause_s = REL_LINE;
          end else if ((char_cnt_q + CW'(1)) == CW'(MAX_LINE)) begin
            rel_cause_s = REL_MAXLEN;
          end else begin
            rel_cause_s = REL_NONE;
          end
        end else if (!own_valid_s) begin
          idle_cnt_d = idle_cnt_q + TW'(1);
          if ((idle_cnt_q + TW'(1)) == TW'(IDLE_TIMEOUT)) begin
            rel_cause_s = REL_TIMEOUT;
          end else begin
            rel_cause_s = REL_NONE;
          end
        end else begin
          // Owner is waiting on downstream backpressure: counters freeze.
          idle_cnt_d = idle_cnt_q;
        end
        if (rel_cause_s != REL_NONE) begin
          state_d       = ARB_IDLE;
          owner_valid_d = 1'b0;
          char_cnt_d    = '0;
          idle_cnt_d    = '0;
          rr_ptr_d      = next_ptr_s;
        end else begin
          state_d = ARB_LOCKED;
        end
      end
      default: begin
        state_d       = ARB_IDLE;
        owner_valid_d = 1'b0;
      end
    endcase
    line_done_d = is_line_rel(rel_cause_s);
    timeout_d   = (rel_cause_s == REL_TIMEOUT);
  end

  // Single output byte stage: load when empty or draining this cycle
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (load_en_s) begin
      tx_valid_d = accept_s;
      if (accept_s) begin
        tx_data_d = own_data_s;
      end else begin
        tx_data_d = tx_data_q;
      end
    end else begin
      tx_valid_d = tx_valid_q;
    end
  end

  // State and output registers; reset drops any held byte and the grant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ARB_IDLE;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      char_cnt_q    <= '0;
      idle_cnt_q    <= '0;
      rr_ptr_q      <= '0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      line_done_q   <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      char_cnt_q    <= char_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      line_done_q   <= line_done_d;
      timeout_q     <= timeout_d;
    end
  end

  assign tx_data_o     = tx_data_q;
  assign tx_valid_o    = tx_valid_q;
  assign owner_o       = owner_q;
  assign owner_valid_o = owner_valid_q;
  assign line_done_o   = line_done_q;
  assign timeout_o     = timeout_q;

endmodule
